ready_valid_to_fifo_read_port: RTL
==================================

Name: ready_valid_to_fifo_read_port

Overview:
Synthesizable producer side of the FIFO-read port protocol (empty/rden/data) used on exported method result ports. It accepts items on a ready/valid input, buffers them in an internal FIFO, and presents them show-ahead to a downstream reader that pops with rden. It is instantiated at the result boundary of exported class methods so that return values never overflow under reader backpressure.

Parameters:
WIDTH, 32, data width in bits.
DEPTH, 32, FIFO capacity in entries; power of two, >= 2.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
valid_in  input  1  upstream item valid
data_in  input  WIDTH  upstream item
rdy_out  output  1  block can accept; transfer occurs when valid_in && rdy_out
empty_out  output  1  no item available to the reader
data_out  output  WIDTH  head item; meaningful only while empty_out=0
rden_in  input  1  reader pops the head item
count_out  output  CNT_W  current occupancy
underflow_out  output  1  sticky: rden_in was seen while empty_out=1

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state is updated on posedge clk.
- Reset values: rdy_out=0, empty_out=1, count_out=0, underflow_out=0; data_out is don't-care. Pointers clear to 0.
- rdy_out rises on the first edge after rst deasserts (count 0 < DEPTH).
- rdy_out, empty_out, count_out and underflow_out are registered. None of them depends combinationally on valid_in or rden_in.
- rdy_out = (next count < DEPTH). This rule applies when full:
  - rdy_out=0, so no push is accepted in that cycle even if rden_in pops.
  - rdy_out returns to 1 on the edge after the pop.
- Push: a push accepted in cycle N writes mem[wr_ptr]. empty_out falls at edge N+1, so latency is 1 cycle with no bypass path.
- Pop: rden_in && !empty_out advances rd_ptr. The next entry, if any, appears on data_out after that edge.
- data_out = mem[rd_ptr], driven combinationally from storage (show-ahead). It is stable while empty_out=0 and rden_in=0.
- Simultaneous push and valid pop: count is unchanged and both pointers advance.
- Push on empty with rden_in=1 in the same cycle: rden_in is a violation. It is ignored, underflow_out is set, and the pushed item is retained.
- Count arithmetic: next_count = count + push - pop. The pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Ordering: strict FIFO; no item is lost or duplicated.
- underflow_out stays set until rst.
- Reset mid-operation: all buffered items are discarded. Outputs return to their reset values at the reset edge. Any in-flight valid_in during reset is dropped.

Decomposition:
- Package kanagawa_fifo_port_pkg holds:
  - a helper function computing count/pointer widths from DEPTH;
  - a typedef for the pointer type, parameterized by DEPTH through a localparam pattern at the use site.
- Sub-module fifo_port_storage: simple dual-port array.
  - Inputs: write enable, write address, write data.
  - Output: asynchronous read at the read address.
- The top level holds the pointers, count, flags and handshake logic.

Test Plan:
- Reset then idle: hold rst for 10 cycles, then release. Required: rdy_out=0 and empty_out=1 during reset; rdy_out=1 one cycle after release; count_out=0.
- Ordered pass-through: push 0..9 (×5 values 0,5,...,45) back-to-back with rden_in held 1 whenever !empty_out. Required: data_out sequence 0,5,...,45; first empty_out=0 exactly 1 cycle after the first push.
- Fill and backpressure: DEPTH=32, rden_in=0, offer 40 items. Required: exactly 32 accepted; rdy_out=0 from the cycle after the 32nd accept; count_out=32. Then pop 1. Required: rdy_out=1 the next cycle, and the 33rd item is accepted in that cycle.
- Simultaneous push/pop at count=5 for 100 cycles. Required: count_out stays 5 and the output order matches the input order.
- Violation: assert rden_in while empty and push value 0xA5 in the same cycle. Required: underflow_out=1 (sticky), and 0xA5 is still read out next.
- Stress: 32768 items with random reader stalls of 1–64 cycles every 1–16 cycles. Required: all values match in order, no loss, underflow_out=0. Then assert rst mid-stream with 10 items buffered. Required: empty_out=1 and count_out=0 after the reset edge.

Source files
------------

// File: rtl/kanagawa_fifo_port_pkg.sv
// rtl/kanagawa_fifo_port_pkg.sv - shared widths and flag bundle for the FIFO read-port producer
package kanagawa_fifo_port_pkg;

  // Pointer width for a power-of-two DEPTH; callers build ptr_t locally from this.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic rdy;
    logic empty;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_port_storage.sv
// rtl/fifo_port_storage.sv - simple dual-port array, synchronous write, asynchronous read
module fifo_port_storage #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ready_valid_to_fifo_read_port.sv
// rtl/ready_valid_to_fifo_read_port.sv - ready/valid in, show-ahead empty/rden/data FIFO read port out
module ready_valid_to_fifo_read_port
  import kanagawa_fifo_port_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             rdy_out,
  output logic             empty_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             rden_in,
  output logic [CNT_W-1:0] count_out,
  output logic             underflow_out
);

  localparam int PTR_W = ptr_width(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] next_count;
  fifo_flags_t      flags_q;
  logic             push;
  logic             pop;

  // Handshakes use only registered flags, so no output path depends on valid_in or rden_in.
  assign push = valid_in && flags_q.rdy;
  assign pop  = rden_in && !flags_q.empty;

  always_comb begin
    next_count = count_q;
    if (push && !pop) begin
      next_count = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      next_count = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_q         <= '0;
      flags_q.rdy       <= 1'b0;
      flags_q.empty     <= 1'b1;
      flags_q.underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      count_q       <= next_count;
      flags_q.rdy   <= (next_count < CNT_W'(DEPTH));
      flags_q.empty <= (next_count == '0);
      if (rden_in && flags_q.empty) begin
        flags_q.underflow <= 1'b1;
      end
    end
  end

  fifo_port_storage #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  assign rdy_out       = flags_q.rdy;
  assign empty_out     = flags_q.empty;
  assign count_out     = count_q;
  assign underflow_out = flags_q.underflow;

endmodule
